// File: rtl/word_serial_tx_pkg.sv
// Shared types and elaboration-time helpers for the word-serial transmitter.
package word_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int frame_bits(input int width, input int parity_en);
        return width + parity_en + 2;
    endfunction

endpackage

// File: rtl/word_serial_tx_xor_reduce.sv
// Parity helper: WIDTH-input XOR as a balanced tree of two-input Xor gates.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic out
);
    assign out = a ^ b;
endmodule

module xor_reduce
    import word_serial_tx_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in_bits,
    output logic             out
);
    localparam int LEAVES = 1 << clog2(WIDTH);

    // Heap-indexed tree: node k combines nodes 2k and 2k+1; leaves start at LEAVES.
    logic node [1:2*LEAVES-1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < WIDTH) begin : g_bit
            assign node[LEAVES+i] = in_bits[i];
        end else begin : g_pad
            assign node[LEAVES+i] = 1'b0;
        end
    end

    for (genvar k = 1; k < LEAVES; k++) begin : g_node
        xor_gate u_xor (
            .a   (node[2*k]),
            .b   (node[2*k+1]),
            .out (node[k])
        );
    end

    assign out = node[1];

endmodule

// File: rtl/word_serial_tx.sv
// Bit-serial frame transmitter: start, WIDTH data bits LSB first, optional even parity, stop.
module word_serial_tx
    import word_serial_tx_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int BW = cnt_width(WIDTH);
    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

    state_t           state, state_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [CW-1:0]    cyc_cnt, cyc_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             par, par_nxt;
    logic             par_calc;
    logic             bit_end;
    logic             tx_nxt, busy_nxt, done_nxt, ready_nxt;

    xor_reduce #(.WIDTH(WIDTH)) u_par (
        .in_bits (in_data),
        .out     (par_calc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            cyc_cnt  <= cyc_nxt;
            shreg    <= shreg_nxt;
            par      <= par_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            in_ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        cyc_nxt   = cyc_cnt;
        shreg_nxt = shreg;
        par_nxt   = par;
        bit_end   = (cyc_cnt == CYC_LAST);

        if (state != IDLE) begin
            cyc_nxt = bit_end ? '0 : cyc_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                // in_ready is low for the first cycle out of reset, so no word is taken then.
                if (in_valid && in_ready) begin
                    shreg_nxt = in_data;
                    par_nxt   = par_calc;
                    bit_nxt   = '0;
                    cyc_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with the state.
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == STOP) && (cyc_nxt == CYC_LAST);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            PARITY:  tx_nxt = par_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule
